// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: responder for the memory-writer strobe interface. It drives timed
// write and read cycles on an asynchronous 256Kx16 SRAM (IS61LV25616).
//
// Ports:
//   SRAM_CLK        system clock; all logic runs on the rising edge
//   reset           asynchronous, active-high reset
//   addr_in         request address, captured on a detected strobe edge
//   data_in         write data, captured on a detected writePulse edge
//   writePulse      a rising edge requests a write
//   readPulse       a rising edge requests a read
//   rdata           last word read, held until the next read completes
//   rdata_valid     one-cycle strobe that marks an rdata update
//   busy            FSM active, or a request is pending
//   overrun         sticky flag: a request edge was dropped
//   SRAM_ADDR/DQ/CE_N/OE_N/WE_N/UB_N/LB_N  SRAM pins; all outputs are registered
module sram_port_ctrl #(
    parameter int unsigned WR_CYCLES      = 2,
    parameter int unsigned RD_WAIT_CYCLES = 2
) (
    input  logic        SRAM_CLK,
    input  logic        reset,
    input  logic [17:0] addr_in,
    input  logic [15:0] data_in,
    input  logic        writePulse,
    input  logic        readPulse,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        overrun,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int unsigned MaxCyc = (WR_CYCLES > RD_WAIT_CYCLES) ? WR_CYCLES : RD_WAIT_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

    typedef enum logic [2:0] {
        StIdle, StWrSetup, StWrStrobe, StWrHold, StRdSetup, StRdWait
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              wp_q, rp_q;
    logic              wfull_q, wfull_d, rfull_q, rfull_d;
    logic [17:0]       waddr_q, waddr_d, raddr_q, raddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              ovr_q, ovr_d;
    logic [17:0]       addr_q, addr_d;
    logic [15:0]       dq_q, dq_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              take_w, take_r;
    logic              w_edge, r_edge;

    assign w_edge = writePulse & ~wp_q;
    assign r_edge = readPulse & ~rp_q;

    // FSM next state and wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take_w  = 1'b0;
        take_r  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wfull_q) begin
                    state_d = StWrSetup;
                    take_w  = 1'b1;
                end else if (rfull_q) begin
                    state_d = StRdSetup;
                    take_r  = 1'b1;
                end
            end
            StWrSetup:  state_d = StWrStrobe;
            StWrStrobe: begin
                if (cnt_q == '0) state_d = StWrHold;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StWrHold:   state_d = StIdle;
            StRdSetup:  state_d = StRdWait;
            StRdWait: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            default:    state_d = StIdle;
        endcase
        // Counter reloads on every state change; only the timed states use it.
        if (state_d != state_q) begin
            unique case (state_d)
                StWrStrobe: cnt_d = CntW'(WR_CYCLES - 1);
                StRdWait:   cnt_d = CntW'(RD_WAIT_CYCLES - 1);
                default:    cnt_d = '0;
            endcase
        end
    end

    // Pending slots. A slot freed this cycle may be refilled by a coincident edge.
    always_comb begin
        wfull_d = wfull_q & ~take_w;
        rfull_d = rfull_q & ~take_r;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        raddr_d = raddr_q;
        ovr_d   = ovr_q;
        if (w_edge) begin
            if (wfull_d) begin
                ovr_d = 1'b1;
            end else begin
                wfull_d = 1'b1;
                waddr_d = addr_in;
                wdata_d = data_in;
            end
        end
        if (r_edge) begin
            if (rfull_d) begin
                ovr_d = 1'b1;
            end else begin
                rfull_d = 1'b1;
                raddr_d = addr_in;
            end
        end
    end

    // Pin values are derived from the next state so the registered pins line up with state_q.
    always_comb begin
        ce_n_d   = (state_d == StIdle);
        we_n_d   = (state_d != StWrStrobe);
        oe_n_d   = !((state_d == StRdSetup) || (state_d == StRdWait));
        dq_oe_d  = (state_d == StWrSetup) || (state_d == StWrStrobe) || (state_d == StWrHold);
        addr_d   = addr_q;
        dq_d     = dq_q;
        if (take_w) begin
            addr_d = waddr_q;
            dq_d   = wdata_q;
        end else if (take_r) begin
            addr_d = raddr_q;
        end
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if ((state_q == StRdWait) && (cnt_q == '0)) begin
            rdata_d  = SRAM_DQ;
            rvalid_d = 1'b1;
        end
    end

    always_ff @(posedge SRAM_CLK or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            wfull_q  <= 1'b0;
            rfull_q  <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            raddr_q  <= '0;
            ovr_q    <= 1'b0;
            addr_q   <= '0;
            dq_q     <= '0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wp_q     <= writePulse;
            rp_q     <= readPulse;
            wfull_q  <= wfull_d;
            rfull_q  <= rfull_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            raddr_q  <= raddr_d;
            ovr_q    <= ovr_d;
            addr_q   <= addr_d;
            dq_q     <= dq_d;
            dq_oe_q  <= dq_oe_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign SRAM_DQ     = dq_oe_q ? dq_q : 16'hzzzz;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_CE_N   = ce_n_q;
    assign SRAM_OE_N   = oe_n_q;
    assign SRAM_WE_N   = we_n_q;
    // Both byte lanes are enabled for the whole access.
    assign SRAM_UB_N   = ce_n_q;
    assign SRAM_LB_N   = ce_n_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
    assign overrun     = ovr_q;
    assign busy        = (state_q != StIdle) | wfull_q | rfull_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
module tb_sram_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic        wp, rp;
    logic [15:0] rdata;
    logic        rvalid, busy, overrun;
    logic [17:0] sram_addr;
    wire  [15:0] dq;
    logic        ce_n, oe_n, we_n, ub_n, lb_n;

    int          n_cmp = 0;
    int          n_err = 0;

    // Behavioural SRAM: 256 words, commits a write when WE_N rises with CE_N still low.
    logic [15:0] mem [0:255];
    int          wr_count;
    logic        we_low;
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    always #5 clk = ~clk;

    sram_port_ctrl dut (
        .SRAM_CLK    (clk),
        .reset       (rst),
        .addr_in     (addr),
        .data_in     (wdata),
        .writePulse  (wp),
        .readPulse   (rp),
        .rdata       (rdata),
        .rdata_valid (rvalid),
        .busy        (busy),
        .overrun     (overrun),
        .SRAM_ADDR   (sram_addr),
        .SRAM_DQ     (dq),
        .SRAM_CE_N   (ce_n),
        .SRAM_OE_N   (oe_n),
        .SRAM_WE_N   (we_n),
        .SRAM_UB_N   (ub_n),
        .SRAM_LB_N   (lb_n)
    );

    assign dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        wr_count = 0;
        we_low   = 1'b0;
        forever begin
            @(negedge clk);
            if (pre_we) mem[pre_addr] = pre_data;
            if (we_n && we_low && !ce_n) begin
                mem[sram_addr[7:0]] = dq;
                wr_count++;
            end
            we_low = !we_n;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // WE_N and OE_N must never be low together.
    always @(negedge clk) begin
        if (!rst) check("we_oe_exclusive", {31'b0, we_n | oe_n}, 32'd1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int windows;
    int low_cycles;
    logic prev_we;

    initial begin
        rst = 1'b1; wp = 1'b0; rp = 1'b0; addr = '0; wdata = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        tick();
        tick();
        // Reset state
        check("rst_we_n", {31'b0, we_n}, 32'd1);
        check("rst_ce_n", {31'b0, ce_n}, 32'd1);
        check("rst_oe_n", {31'b0, oe_n}, 32'd1);
        check("rst_ublb", {30'b0, ub_n, lb_n}, 32'd3);
        check("rst_addr", {14'b0, sram_addr}, 32'd0);
        check("rst_rdata", {16'b0, rdata}, 32'd0);
        check("rst_flags", {29'b0, rvalid, busy, overrun}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: single write
        wp = 1'b1; addr = 18'h5; wdata = 16'hAAAA;
        tick();
        check("t1_busy_pending", {31'b0, busy}, 32'd1);
        check("t1_idle_ce", {31'b0, ce_n}, 32'd1);
        tick();
        check("t1_setup_addr", {14'b0, sram_addr}, 32'h5);
        check("t1_setup_dq", {16'b0, dq}, 32'hAAAA);
        check("t1_setup_ctl", {27'b0, ce_n, ub_n, lb_n, we_n, oe_n}, 32'b00011);
        tick();
        check("t1_strobe1_we", {31'b0, we_n}, 32'd0);
        tick();
        check("t1_strobe2_we", {31'b0, we_n}, 32'd0);
        tick();
        check("t1_hold_we", {31'b0, we_n}, 32'd1);
        check("t1_hold_dq", {16'b0, dq}, 32'hAAAA);
        tick();
        check("t1_done_busy", {31'b0, busy}, 32'd0);
        check("t1_done_ce", {31'b0, ce_n}, 32'd1);
        check("t1_mem", {16'b0, mem[5]}, 32'hAAAA);
        check("t1_wr_count", wr_count, 32'd1);
        wp = 1'b0;
        tick();

        // 2: read of a preloaded word
        @(negedge clk);
        pre_addr = 8'h5; pre_data = 16'h1234; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
        tick();
        rp = 1'b1;
        tick();
        check("t2_busy_pending", {31'b0, busy}, 32'd1);
        tick();
        check("t2_setup_oe", {30'b0, oe_n, we_n}, 32'b01);
        check("t2_setup_dq", {16'b0, dq}, 32'h1234);
        check("t2_setup_valid", {31'b0, rvalid}, 32'd0);
        tick();
        check("t2_wait1_valid", {31'b0, rvalid}, 32'd0);
        tick();
        check("t2_wait2_valid", {31'b0, rvalid}, 32'd0);
        tick();
        check("t2_rdata", {16'b0, rdata}, 32'h1234);
        check("t2_valid", {31'b0, rvalid}, 32'd1);
        rp = 1'b0;
        tick();
        check("t2_valid_drop", {31'b0, rvalid}, 32'd0);
        check("t2_rdata_held", {16'b0, rdata}, 32'h1234);
        check("t2_idle_busy", {31'b0, busy}, 32'd0);

        // 3: simultaneous write and read edges
        wp = 1'b1; rp = 1'b1; addr = 18'h5; wdata = 16'hAAAA;
        tick();
        tick();
        check("t3_wr_first", {30'b0, we_n, oe_n}, 32'b11);
        check("t3_wr_ce", {31'b0, ce_n}, 32'd0);
        wp = 1'b0; rp = 1'b0;
        repeat (4) tick();
        check("t3_gap_ce", {31'b0, ce_n}, 32'd1);
        check("t3_gap_busy", {31'b0, busy}, 32'd1);
        tick();
        check("t3_rd_oe", {31'b0, oe_n}, 32'd0);
        repeat (3) tick();
        check("t3_rdata", {16'b0, rdata}, 32'hAAAA);
        check("t3_valid", {31'b0, rvalid}, 32'd1);
        check("t3_overrun", {31'b0, overrun}, 32'd0);
        check("t3_wr_count", wr_count, 32'd2);
        tick();

        // 4: edges during an active write
        wp = 1'b1; addr = 18'd10; wdata = 16'h1111;
        tick();
        wp = 1'b0;
        tick();
        wp = 1'b1; addr = 18'd11; wdata = 16'h2222;
        tick();
        check("t4_no_ovr_yet", {31'b0, overrun}, 32'd0);
        wp = 1'b0;
        tick();
        wp = 1'b1; addr = 18'd12; wdata = 16'h3333;
        tick();
        check("t4_overrun", {31'b0, overrun}, 32'd1);
        wp = 1'b0;
        tick();
        tick();
        check("t4_second_addr", {14'b0, sram_addr}, 32'd11);
        check("t4_second_dq", {16'b0, dq}, 32'h2222);
        repeat (4) tick();
        check("t4_busy_done", {31'b0, busy}, 32'd0);
        check("t4_mem10", {16'b0, mem[10]}, 32'h1111);
        check("t4_mem11", {16'b0, mem[11]}, 32'h2222);
        check("t4_mem12", {16'b0, mem[12]}, 32'h0);
        check("t4_wr_count", wr_count, 32'd4);
        check("t4_ovr_sticky", {31'b0, overrun}, 32'd1);

        // 5: reset during the write strobe
        wp = 1'b1; addr = 18'd20; wdata = 16'h5555;
        tick();
        wp = 1'b0;
        tick();
        tick();
        check("t5_in_strobe", {31'b0, we_n}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_ctl", {29'b0, we_n, ce_n, oe_n}, 32'b111);
        check("t5_rst_busy", {31'b0, busy}, 32'd0);
        check("t5_rst_ovr", {31'b0, overrun}, 32'd0);
        check("t5_rst_rdata", {16'b0, rdata}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t5_mem20", {16'b0, mem[20]}, 32'h0);
        check("t5_wr_count", wr_count, 32'd4);

        // 6: held writePulse yields exactly one write window
        wp = 1'b1; addr = 18'd30; wdata = 16'h6666;
        windows = 0; low_cycles = 0; prev_we = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!we_n) low_cycles++;
            if (!we_n && prev_we) windows++;
            prev_we = we_n;
        end
        wp = 1'b0;
        tick();
        check("t6_windows", windows, 32'd1);
        check("t6_low_cycles", low_cycles, 32'd2);
        check("t6_mem30", {16'b0, mem[30]}, 32'h6666);
        check("t6_wr_count", wr_count, 32'd5);
        check("t6_busy", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
